// File: rtl/led_trail_fader_if.sv
// LED request/drive bundle between the walker side (master) and the trail fader (slave).
interface led_trail_fader_if #(
  parameter int NLEDS = 8
);
  logic             i_ce;
  logic [NLEDS-1:0] i_led;
  logic [NLEDS-1:0] o_led;
  logic             o_busy;

  modport master (output i_ce, i_led, input o_led, o_busy);
  modport slave  (input i_ce, i_led, output o_led, o_busy);
endinterface

// File: rtl/led_trail_fader.sv
// Comet-tail fader: lit LEDs jump to full brightness, decay one level per period, PWM-rendered.
// Latency: i_led sampled at edge n -> o_led after edge n+1; no backpressure, input always accepted.
module led_trail_fader #(
  parameter int NLEDS        = 8,
  parameter int BW           = 4,
  parameter int DECAY_PERIOD = 4
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  led_trail_fader_if.slave   bus
);

  localparam logic [BW-1:0] MAX   = '1;
  localparam int            DW    = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DECAY_PERIOD - 1);

  logic [BW-1:0]             pwm_cnt_q,   pwm_cnt_d;
  logic [DW-1:0]             decay_cnt_q, decay_cnt_d;
  logic [NLEDS-1:0][BW-1:0]  level_q,     level_d;
  logic [NLEDS-1:0]          o_led_q,     o_led_d;
  logic                      decay_stb;

  always_comb begin
    pwm_cnt_d   = pwm_cnt_q + 1'b1;
    decay_stb   = (decay_cnt_q == DLAST);
    decay_cnt_d = decay_stb ? '0 : decay_cnt_q + 1'b1;
    level_d     = level_q;
    o_led_d     = '0;
    for (int k = 0; k < NLEDS; k++) begin
      // A fresh request wins over a coincident decay step.
      if (bus.i_ce && bus.i_led[k]) begin
        level_d[k] = MAX;
      end else if (decay_stb && (level_q[k] != '0)) begin
        level_d[k] = level_q[k] - 1'b1;
      end
      // MAX is forced on so full brightness is a true 100% duty.
      o_led_d[k] = (level_q[k] == MAX) || (level_q[k] > pwm_cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt_q   <= '0;
      decay_cnt_q <= '0;
      level_q     <= '0;
      o_led_q     <= '0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      level_q     <= level_d;
      o_led_q     <= o_led_d;
    end
  end

  assign bus.o_led  = o_led_q;
  assign bus.o_busy = |level_q;

endmodule
